// File: rtl/menu_nav_ctrl.sv
// Three-level menu controller (TOP -> EDIT -> RUN) driven by debounced key pulses,
// with held-key auto-repeat for field editing and an apply strobe on entry to RUN.
module menu_nav_ctrl #(
  parameter int N_PAGES  = 3,
  parameter int N_FIELDS = 4,
  parameter int FIELD_W  = 2,
  parameter int RPT_DLY  = 25000000,
  parameter int RPT_PER  = 5000000,
  localparam int PW = $clog2(N_PAGES),
  localparam int FW = $clog2(N_FIELDS + 1),
  localparam int VW = N_FIELDS * FIELD_W
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          left,
  input  logic          right,
  input  logic          up,
  input  logic          down,
  input  logic          confirm,
  input  logic          quit,
  input  logic          hold_left,
  input  logic          hold_right,
  output logic [1:0]    state,
  output logic [PW-1:0] page_sel,
  output logic [FW-1:0] field_sel,
  output logic [VW-1:0] field_val,
  output logic [VW-1:0] param_out,
  output logic          run,
  output logic          apply_pulse
);

  localparam int CW = $clog2(RPT_DLY + 1);
  localparam logic [PW-1:0] PG_MAX      = PW'(N_PAGES - 1);
  localparam logic [FW-1:0] APPLY_ROW   = FW'(N_FIELDS);
  localparam logic [CW-1:0] RPT_FIRE_AT = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] RPT_RELOAD  = CW'(RPT_DLY - RPT_PER);

  typedef enum logic [1:0] {
    S_TOP  = 2'd0,
    S_EDIT = 2'd1,
    S_RUN  = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   last_page_reg;
  logic [CW-1:0]   rpt_cnt_reg;
  logic [VW-1:0]   field_val_next;

  logic lr_ok, ud_ok, rpt_active, hold_one, rpt_fire, step_left, step_right;

  assign state = state_reg;

  assign lr_ok      = left ^ right;
  assign ud_ok      = up ^ down;
  assign hold_one   = hold_left ^ hold_right;
  assign rpt_active = (state_reg == S_EDIT) && (field_sel < APPLY_ROW);
  assign rpt_fire   = rpt_active && hold_one && (rpt_cnt_reg == RPT_FIRE_AT);

  // A real key pulse wins over a coincident repeat step, so at most one step per cycle.
  assign step_left  = lr_ok ? left  : (rpt_fire & hold_left);
  assign step_right = lr_ok ? right : (rpt_fire & hold_right);

  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
      logic [FIELD_W-1:0] cur;
      logic               sel;
      assign cur = field_val[gi*FIELD_W +: FIELD_W];
      assign sel = (field_sel == FW'(gi));
      assign field_val_next[gi*FIELD_W +: FIELD_W] =
        !sel       ? cur :
        step_right ? cur + FIELD_W'(1) :
        step_left  ? cur - FIELD_W'(1) : cur;
    end
  endgenerate

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_reg     <= S_TOP;
      page_sel      <= '0;
      field_sel     <= '0;
      field_val     <= '0;
      param_out     <= '0;
      run           <= 1'b0;
      apply_pulse   <= 1'b0;
      rpt_cnt_reg   <= '0;
      last_page_reg <= '0;
    end else begin
      apply_pulse <= 1'b0;
      case (state_reg)
        S_TOP: begin
          rpt_cnt_reg <= '0;
          if (quit) begin
            // quit has nothing to leave from TOP, but still masks the other keys
          end else if (confirm) begin
            state_reg     <= S_EDIT;
            field_sel     <= '0;
            last_page_reg <= page_sel;
            if (page_sel != last_page_reg)
              field_val <= '0;
          end else if (lr_ok && left) begin
            page_sel <= (page_sel == '0) ? PG_MAX : page_sel - PW'(1);
          end else if (lr_ok && right) begin
            page_sel <= (page_sel == PG_MAX) ? '0 : page_sel + PW'(1);
          end
        end

        S_EDIT: begin
          if (quit) begin
            state_reg   <= S_TOP;
            field_sel   <= '0;
            rpt_cnt_reg <= '0;
          end else if (confirm && field_sel == APPLY_ROW) begin
            state_reg   <= S_RUN;
            param_out   <= field_val;
            run         <= 1'b1;
            apply_pulse <= 1'b1;
            rpt_cnt_reg <= '0;
          end else if (ud_ok) begin
            if (up)
              field_sel <= (field_sel == '0) ? APPLY_ROW : field_sel - FW'(1);
            else
              field_sel <= (field_sel == APPLY_ROW) ? '0 : field_sel + FW'(1);
            rpt_cnt_reg <= '0;
          end else begin
            field_val <= field_val_next;
            // After the first step, reload so later steps come every RPT_PER cycles.
            if (rpt_active && hold_one)
              rpt_cnt_reg <= rpt_fire ? RPT_RELOAD : rpt_cnt_reg + CW'(1);
            else
              rpt_cnt_reg <= '0;
          end
        end

        S_RUN: begin
          rpt_cnt_reg <= '0;
          if (quit) begin
            state_reg <= S_EDIT;
            run       <= 1'b0;
            field_sel <= APPLY_ROW;
          end
        end

        default: begin
          state_reg   <= S_TOP;
          page_sel    <= '0;
          field_sel   <= '0;
          run         <= 1'b0;
          rpt_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Table-driven scoreboard bench for menu_nav_ctrl with fast repeat timing.
module tb_menu_nav_ctrl;

  localparam logic [5:0] K_0 = 6'b000000;
  localparam logic [5:0] K_L = 6'b100000;
  localparam logic [5:0] K_R = 6'b010000;
  localparam logic [5:0] K_U = 6'b001000;
  localparam logic [5:0] K_D = 6'b000100;
  localparam logic [5:0] K_C = 6'b000010;
  localparam logic [5:0] K_Q = 6'b000001;

  logic       clk_50M, rst_n;
  logic       left, right, up, down, confirm, quit, hold_left, hold_right;
  logic [1:0] state;
  logic [1:0] page_sel;
  logic [2:0] field_sel;
  logic [7:0] field_val, param_out;
  logic       run, apply_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [5:0] keys;
    logic       hl, hr;
    logic [1:0] st;
    logic [1:0] pg;
    logic [2:0] fs;
    logic [7:0] fv;
    logic [7:0] po;
    logic       run;
    logic       ap;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  menu_nav_ctrl #(
    .N_PAGES(3), .N_FIELDS(4), .FIELD_W(2), .RPT_DLY(20), .RPT_PER(5)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .left(left), .right(right), .up(up), .down(down),
    .confirm(confirm), .quit(quit),
    .hold_left(hold_left), .hold_right(hold_right),
    .state(state), .page_sel(page_sel), .field_sel(field_sel),
    .field_val(field_val), .param_out(param_out),
    .run(run), .apply_pulse(apply_pulse)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  function automatic vec_t mk(input string name, input logic r, input logic [5:0] k,
                              input logic hl, input logic hr,
                              input logic [1:0] st, input logic [1:0] pg, input logic [2:0] fs,
                              input logic [7:0] fv, input logic [7:0] po,
                              input logic rn, input logic ap);
    vec_t v;
    v.name = name; v.rst_n = r; v.keys = k; v.hl = hl; v.hr = hr;
    v.st = st; v.pg = pg; v.fs = fs; v.fv = fv; v.po = po; v.run = rn; v.ap = ap;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    logic [24:0] got, want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got output with no expectation queued, required one");
      return;
    end
    e    = exp_q.pop_front();
    got  = {state, page_sel, field_sel, field_val, param_out, run, apply_pulse};
    want = {e.st, e.pg, e.fs, e.fv, e.po, e.run, e.ap};
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d pg=%0d fs=%0d fv=%h po=%h run=%b ap=%b, required st=%0d pg=%0d fs=%0d fv=%h po=%h run=%b ap=%b",
               e.name, state, page_sel, field_sel, field_val, param_out, run, apply_pulse,
               e.st, e.pg, e.fs, e.fv, e.po, e.run, e.ap);
    end else begin
      $display("ok   %s: st=%0d pg=%0d fs=%0d fv=%h po=%h run=%b ap=%b",
               e.name, state, page_sel, field_sel, field_val, param_out, run, apply_pulse);
    end
  endtask

  task automatic step(input vec_t v);
    rst_n = v.rst_n;
    {left, right, up, down, confirm, quit} = v.keys;
    hold_left  = v.hl;
    hold_right = v.hr;
    exp_q.push_back(v);
    @(posedge clk_50M);
    #1;
    check_out();
  endtask

  initial begin
    logic [1:0] f1;
    rst_n = 1'b0;
    {left, right, up, down, confirm, quit} = K_0;
    hold_left = 1'b0; hold_right = 1'b0;

    // name, rst_n, keys, hl, hr | st, pg, fs, fv, po, run, ap
    tbl.push_back(mk("reset0",          0, K_0,       0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("reset1",          0, K_0,       0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_left_wrap",   1, K_L,       0, 0, 0, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_right_wrap",  1, K_R,       0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_right",       1, K_R,       0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_lr_ignored",  1, K_L | K_R, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_quit_noop",   1, K_Q,       0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("top_confirm",     1, K_C,       0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk("edit_f0_dec",     1, K_L,       0, 0, 1, 1, 0, 8'h03, 8'h00, 0, 0));
    tbl.push_back(mk("edit_lr_ignored", 1, K_L | K_R, 0, 0, 1, 1, 0, 8'h03, 8'h00, 0, 0));
    tbl.push_back(mk("edit_down1",      1, K_D,       0, 0, 1, 1, 1, 8'h03, 8'h00, 0, 0));
    tbl.push_back(mk("edit_f1_inc",     1, K_R,       0, 0, 1, 1, 1, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("edit_ud_ignored", 1, K_U | K_D, 0, 0, 1, 1, 1, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("edit_down2",      1, K_D,       0, 0, 1, 1, 2, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("edit_down3",      1, K_D,       0, 0, 1, 1, 3, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("edit_down_apply", 1, K_D,       0, 0, 1, 1, 4, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("apply_left_noop", 1, K_L,       0, 0, 1, 1, 4, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("apply_right_noop",1, K_R,       0, 0, 1, 1, 4, 8'h07, 8'h00, 0, 0));
    tbl.push_back(mk("apply_confirm",   1, K_C,       0, 0, 2, 1, 4, 8'h07, 8'h07, 1, 1));
    tbl.push_back(mk("run_pulse_drop",  1, K_0,       0, 0, 2, 1, 4, 8'h07, 8'h07, 1, 0));
    tbl.push_back(mk("run_left_ign",    1, K_L,       0, 0, 2, 1, 4, 8'h07, 8'h07, 1, 0));
    tbl.push_back(mk("run_confirm_ign", 1, K_C,       0, 0, 2, 1, 4, 8'h07, 8'h07, 1, 0));
    tbl.push_back(mk("run_down_ign",    1, K_D,       0, 0, 2, 1, 4, 8'h07, 8'h07, 1, 0));
    tbl.push_back(mk("run_quit",        1, K_Q,       0, 0, 1, 1, 4, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("edit_down_wrap",  1, K_D,       0, 0, 1, 1, 0, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("edit_up_wrap",    1, K_U,       0, 0, 1, 1, 4, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("quit_over_conf",  1, K_Q | K_C, 0, 0, 0, 1, 0, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("reenter_same_pg", 1, K_C,       0, 0, 1, 1, 0, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("confirm_row0_nop",1, K_C,       0, 0, 1, 1, 0, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("edit_down_f1",    1, K_D,       0, 0, 1, 1, 1, 8'h07, 8'h07, 0, 0));
    tbl.push_back(mk("edit_f1_to0",     1, K_L,       0, 0, 1, 1, 1, 8'h03, 8'h07, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // hold_right for 35 cycles on field 1: steps land on held cycles 20, 25, 30, 35
    for (int k = 1; k <= 35; k++) begin
      f1 = (k < 20) ? 2'd0 : 2'((((k - 20) / 5) + 1) % 4);
      step(mk($sformatf("hold_right_c%0d", k), 1, K_0, 0, 1, 1, 1, 1,
              {4'b0000, f1, 2'b11}, 8'h07, 0, 0));
    end
    step(mk("hold_release", 1, K_0, 0, 0, 1, 1, 1, 8'h03, 8'h07, 0, 0));

    // both holds high keep the counter cleared, so nothing should ever step
    for (int k = 1; k <= 25; k++)
      step(mk($sformatf("hold_both_c%0d", k), 1, K_0, 1, 1, 1, 1, 1, 8'h03, 8'h07, 0, 0));

    step(mk("edit_quit_keep",   1, K_Q, 0, 0, 0, 1, 0, 8'h03, 8'h07, 0, 0));
    step(mk("top_to_pg2",       1, K_R, 0, 0, 0, 2, 0, 8'h03, 8'h07, 0, 0));
    step(mk("new_page_clears",  1, K_C, 0, 0, 1, 2, 0, 8'h00, 8'h07, 0, 0));
    step(mk("pg2_f0_dec",       1, K_L, 0, 0, 1, 2, 0, 8'h03, 8'h07, 0, 0));
    for (int k = 1; k <= 4; k++)
      step(mk($sformatf("pg2_down%0d", k), 1, K_D, 0, 0, 1, 2, 3'(k), 8'h03, 8'h07, 0, 0));
    step(mk("pg2_apply",        1, K_C, 0, 0, 2, 2, 4, 8'h03, 8'h03, 1, 1));
    step(mk("reset_in_apply",   0, K_Q | K_C, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    step(mk("post_reset_idle",  1, K_0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    step(mk("reenter_pg0",      1, K_C, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    step(mk("final_idle",       1, K_0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0));

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
